// File: rtl/mem_wr_pkg.sv
// mem_wr_pkg
// Shared types and default sizing for the memory-side write responder.
//   mem_wr_state_e : responder FSM states (IDLE / WR / RD)
//   MEM_WR_ADDR_W  : default address width
//   MEM_WR_DATA_W  : default data width
//   MEM_WR_DEPTH   : default write FIFO depth (power of two, >= 4)
package mem_wr_pkg;

  localparam int MEM_WR_ADDR_W = 64;
  localparam int MEM_WR_DATA_W = 64;
  localparam int MEM_WR_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } mem_wr_state_e;

endpackage

// File: rtl/mem_wr_fifo.sv
// mem_wr_fifo
// Circular write buffer for the L2 drain stream, with address compare against
// every valid entry so reads can detect pending writes to the same address.
// Optional macro MEM_WR_FWD_EN adds the youngest-match data output.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   push_req, push_addr/data : incoming beat (dropped when full and not popping)
//   pop                   : retire head entry
//   cmp_addr              : address compared against all valid entries
//   head_addr/data        : oldest entry
//   next_addr/data        : entry behind the head (presented after a pop)
//   count                 : number of valid entries
//   overflow              : beat dropped this cycle
//   match_age             : match vector indexed by age, bit 0 = head
//   fwd_data              : data of youngest matching entry (MEM_WR_FWD_EN only)
module mem_wr_fifo
  import mem_wr_pkg::*;
#(
  parameter int ADDR_W = MEM_WR_ADDR_W,
  parameter int DATA_W = MEM_WR_DATA_W,
  parameter int DEPTH  = MEM_WR_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_req,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic [ADDR_W-1:0]      cmp_addr,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [ADDR_W-1:0]      next_addr,
  output logic [DATA_W-1:0]      next_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DEPTH-1:0]       match_age
`ifdef MEM_WR_FWD_EN
  ,
  output logic [DATA_W-1:0]      fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  idx;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_ok   = pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop_ok);
  assign overflow = push_req && full && !pop_ok;

  assign next_ptr  = rd_ptr_q + 1'b1;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign next_addr = addr_q[next_ptr];
  assign next_data = data_q[next_ptr];
  assign count     = count_q;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    match_age = '0;
    idx       = '0;
`ifdef MEM_WR_FWD_EN
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == cmp_addr)) begin
        match_age[k] = 1'b1;
`ifdef MEM_WR_FWD_EN
        fwd_data     = data_q[idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count/pointers.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/mem_write_responder.sv
// mem_write_responder
// Memory-side endpoint of the L2 write-through drain. Buffers single-beat
// writes in a FIFO, retires them to the device port, serves reads with
// priority over buffered writes and throttles the L2 via read_stop_en.
// Optional macro MEM_WR_FWD_EN: reads hitting the FIFO return the youngest
// matching data without a device access; otherwise such reads wait until no
// buffered write matches.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   mem_start_write, mem_adderss_write, mem_data_write : write beat from L2
//   read_stop_en               : registered back-pressure to L2
//   rd_req, rd_adderss         : level read request and address
//   rd_data, rd_valid          : read result and one-cycle valid pulse
//   dev_adderss, dev_wdata, dev_we, dev_re : device request
//   dev_rdata, dev_ready       : device response
//   overflow_err               : sticky, beat arrived while FIFO full
module mem_write_responder
  import mem_wr_pkg::*;
#(
  parameter int ADDR_W     = MEM_WR_ADDR_W,
  parameter int DATA_W     = MEM_WR_DATA_W,
  parameter int FIFO_DEPTH = MEM_WR_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_adderss_write,
  input  logic [DATA_W-1:0] mem_data_write,
  input  logic              mem_start_write,
  output logic              read_stop_en,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_adderss,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] dev_adderss,
  output logic [DATA_W-1:0] dev_wdata,
  output logic              dev_we,
  output logic              dev_re,
  input  logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_ready,
  output logic              overflow_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  mem_wr_state_e     state_q, state_d;
  logic              dev_we_q, dev_we_d;
  logic              dev_re_q, dev_re_d;
  logic [ADDR_W-1:0] dev_addr_q, dev_addr_d;
  logic [DATA_W-1:0] dev_wdata_q, dev_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              read_stop_q, read_stop_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0]    head_addr, next_addr, sel_addr;
  logic [DATA_W-1:0]    head_data, next_data, sel_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_overflow;
  logic [FIFO_DEPTH-1:0] match_age;
  logic [FIFO_DEPTH-1:0] match_live;
  logic                 wr_done, rd_done, decide, rd_pend, more_writes;
`ifdef MEM_WR_FWD_EN
  logic [DATA_W-1:0]    fwd_data;
`endif

  mem_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_req  (mem_start_write),
    .push_addr (mem_adderss_write),
    .push_data (mem_data_write),
    .pop       (wr_done),
    .cmp_addr  (rd_adderss),
    .head_addr (head_addr),
    .head_data (head_data),
    .next_addr (next_addr),
    .next_data (next_data),
    .count     (fifo_count),
    .overflow  (fifo_overflow),
    .match_age (match_age)
`ifdef MEM_WR_FWD_EN
    ,
    .fwd_data  (fwd_data)
`endif
  );

  assign wr_done = (state_q == WR) && dev_ready;
  assign rd_done = (state_q == RD) && dev_ready;
  assign decide  = (state_q == IDLE) || wr_done || rd_done;

  // The request stays high through the rd_valid cycle and through the edge
  // that completes it, so neither may start a second read.
  assign rd_pend = rd_req && !rd_valid_q && !rd_done;

  // When the head retires this cycle, only entries behind it remain.
  assign more_writes = wr_done ? (fifo_count > CNT_W'(1)) : (fifo_count != '0);
  assign sel_addr    = wr_done ? next_addr : head_addr;
  assign sel_data    = wr_done ? next_data : head_data;

  always_comb begin
    match_live = match_age;
    if (wr_done) begin
      match_live[0] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dev_we_d    = dev_we_q;
    dev_re_d    = dev_re_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    if (decide) begin
      state_d  = IDLE;
      dev_we_d = 1'b0;
      dev_re_d = 1'b0;
      if (rd_pend) begin
`ifdef MEM_WR_FWD_EN
        if (|match_age) begin
          rd_data_d  = fwd_data;
          rd_valid_d = 1'b1;
        end else begin
          state_d    = RD;
          dev_re_d   = 1'b1;
          dev_addr_d = rd_adderss;
        end
`else
        // A read hitting a buffered write waits until that write has retired.
        if (|match_live) begin
          state_d     = WR;
          dev_we_d    = 1'b1;
          dev_addr_d  = sel_addr;
          dev_wdata_d = sel_data;
        end else begin
          state_d    = RD;
          dev_re_d   = 1'b1;
          dev_addr_d = rd_adderss;
        end
`endif
      end else if (more_writes) begin
        state_d     = WR;
        dev_we_d    = 1'b1;
        dev_addr_d  = sel_addr;
        dev_wdata_d = sel_data;
      end
    end
    if (rd_done) begin
      rd_data_d  = dev_rdata;
      rd_valid_d = 1'b1;
    end
  end

  // One slot below full is reserved: L2 sees stop one edge late and may
  // already have a beat in flight.
  assign read_stop_d = rd_req || (state_q == RD) ||
                       (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
  assign overflow_d  = overflow_q || fifo_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dev_we_q    <= 1'b0;
      dev_re_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      read_stop_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dev_we_q    <= dev_we_d;
      dev_re_q    <= dev_re_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      read_stop_q <= read_stop_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dev_we       = dev_we_q;
  assign dev_re       = dev_re_q;
  assign dev_adderss  = dev_addr_q;
  assign dev_wdata    = dev_wdata_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign read_stop_en = read_stop_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_mem_write_responder.sv
// tb_mem_write_responder
// Drives the L2 write stream and read port, models the memory device with
// a programmable latency, and checks device writes and read results against
// queues of expected values filled when stimulus is applied.
module tb_mem_write_responder;

  localparam logic [63:0] RD_PAT = 64'hA5A5_0000_5A5A_FFFF;

  logic        clk;
  logic        reset;
  logic [63:0] mem_adderss_write;
  logic [63:0] mem_data_write;
  logic        mem_start_write;
  logic        read_stop_en;
  logic        rd_req;
  logic [63:0] rd_adderss;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [63:0] dev_adderss;
  logic [63:0] dev_wdata;
  logic        dev_we;
  logic        dev_re;
  logic [63:0] dev_rdata;
  logic        dev_ready;
  logic        overflow_err;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wexp_t;

  typedef struct {
    bit          is_rd;
    logic [63:0] addr;
    logic [63:0] data;
    int          lat;
  } vec_t;

  wexp_t       wq[$];
  logic [63:0] rq[$];
  logic [63:0] dmem [logic [63:0]];
  vec_t        vecs[8];

  int total = 0;
  int bad   = 0;
  int dev_lat = 1;
  bit dev_hold = 0;
  int wait_cnt = 0;
  int wr_done = 0;
  int rd_at_wr = 0;
  int re_cycles = 0;
  int we_cycles = 0;
  int rv_cnt = 0;

  mem_write_responder dut (
    .clk               (clk),
    .reset             (reset),
    .mem_adderss_write (mem_adderss_write),
    .mem_data_write    (mem_data_write),
    .mem_start_write   (mem_start_write),
    .read_stop_en      (read_stop_en),
    .rd_req            (rd_req),
    .rd_adderss        (rd_adderss),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .dev_adderss       (dev_adderss),
    .dev_wdata         (dev_wdata),
    .dev_we            (dev_we),
    .dev_re            (dev_re),
    .dev_rdata         (dev_rdata),
    .dev_ready         (dev_ready),
    .overflow_err      (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device model and scoreboard consumer, evaluated mid-cycle.
  initial begin
    dev_ready = 1'b0;
    dev_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dev_ready = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (rd_valid) begin
          rv_cnt++;
          if (rq.size() == 0) begin
            checkOutput("unexpected_rd_valid", 64'(rd_valid), 64'd0);
          end else begin
            logic [63:0] e;
            e = rq.pop_front();
            checkOutput("rd_data", rd_data, e);
          end
        end
        if (dev_we) we_cycles++;
        if (dev_re) re_cycles++;
        if ((dev_we || dev_re) && !dev_hold) begin
          if (wait_cnt >= dev_lat - 1) begin
            dev_ready = 1'b1;
            wait_cnt  = 0;
            if (dev_we) begin
              if (wq.size() == 0) begin
                checkOutput("unexpected_dev_we", 64'(dev_we), 64'd0);
              end else begin
                wexp_t w;
                w = wq.pop_front();
                checkOutput("dev_adderss", dev_adderss, w.addr);
                checkOutput("dev_wdata", dev_wdata, w.data);
              end
              dmem[dev_adderss] = dev_wdata;
              wr_done++;
            end else begin
              dev_rdata = dmem.exists(dev_adderss) ? dmem[dev_adderss] : (dev_adderss ^ RD_PAT);
              rd_at_wr  = wr_done;
            end
          end else begin
            dev_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          dev_ready = 1'b0;
          wait_cnt  = 0;
        end
      end
    end
  end

  // Drive one beat for one clock edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d, input bit accept);
    wexp_t w;
    mem_start_write   = 1'b1;
    mem_adderss_write = a;
    mem_data_write    = d;
    if (accept) begin
      w.addr = a;
      w.data = d;
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    mem_start_write = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (!(wq.size() == 0 && rq.size() == 0 && !dev_we && !dev_re) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_drain_timeout"}, 64'(n >= 400), 64'd0);
    if (n >= 400) begin
      wq.delete();
      rq.delete();
    end
  endtask

  task automatic doRead(input logic [63:0] a, input logic [63:0] exp, input string name);
    int n;
    n = 0;
    rq.push_back(exp);
    rd_adderss = a;
    rd_req     = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rd_valid && n < 200);
    rd_req = 1'b0;
    checkOutput({name, "_rd_timeout"}, 64'(n >= 200), 64'd0);
    if (n >= 200) rq.delete();
  endtask

  initial begin
    int wd0;
    int re0;
    int rv0;
    int n;

    vecs[0] = '{1'b0, 64'h1000, 64'h1111_2222, 1};
    vecs[1] = '{1'b0, 64'h1008, 64'hDEAD_BEEF, 3};
    vecs[2] = '{1'b1, 64'h2000, 64'h2000 ^ RD_PAT, 2};
    vecs[3] = '{1'b0, 64'h1010, 64'h5555, 1};
    vecs[4] = '{1'b1, 64'h1008, 64'hDEAD_BEEF, 1};
    vecs[5] = '{1'b1, 64'h3000, 64'h3000 ^ RD_PAT, 4};
    vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 1};

    reset             = 1'b1;
    mem_start_write   = 1'b0;
    mem_adderss_write = '0;
    mem_data_write    = '0;
    rd_req            = 1'b0;
    rd_adderss        = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dev_we", 64'(dev_we), 64'd0);
    checkOutput("rst_dev_re", 64'(dev_re), 64'd0);
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_read_stop_en", 64'(read_stop_en), 64'd0);
    checkOutput("rst_overflow_err", 64'(overflow_err), 64'd0);
    checkOutput("rst_rd_data", rd_data, 64'd0);
    checkOutput("rst_dev_adderss", dev_adderss, 64'd0);
    checkOutput("rst_dev_wdata", dev_wdata, 64'd0);
    checkOutput("rst_count", 64'(dut.fifo_count), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single write");
    dev_lat   = 2;
    we_cycles = 0;
    applyStimulus(64'h100, 64'hAA, 1'b1);
    checkOutput("single_we_not_yet", 64'(dev_we), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("single_we_up", 64'(dev_we), 64'd1);
    checkOutput("single_addr", dev_adderss, 64'h100);
    checkOutput("single_data", dev_wdata, 64'hAA);
    waitDrain("single");
    checkOutput("single_we_cycles", 64'(we_cycles), 64'd2);
    checkOutput("single_count", 64'(dut.fifo_count), 64'd0);

    $display("[TB] read between buffered writes");
    dev_hold = 1'b1;
    dev_lat  = 1;
    applyStimulus(64'h10, 64'h1, 1'b1);
    applyStimulus(64'h20, 64'h2, 1'b1);
    applyStimulus(64'h30, 64'h3, 1'b1);
    wd0      = wr_done;
    dev_hold = 1'b0;
    doRead(64'h200, 64'h200 ^ RD_PAT, "prio");
    waitDrain("prio");
    checkOutput("prio_rd_after_one_wr", 64'(rd_at_wr), 64'(wd0 + 1));
    checkOutput("prio_all_writes", 64'(wr_done), 64'(wd0 + 3));

    $display("[TB] read after write hazard");
    dev_hold = 1'b1;
    applyStimulus(64'h300, 64'h11, 1'b1);
    applyStimulus(64'h300, 64'h22, 1'b1);
    wd0      = wr_done;
    re0      = re_cycles;
    dev_hold = 1'b0;
    doRead(64'h300, 64'h22, "raw");
    waitDrain("raw");
`ifdef MEM_WR_FWD_EN
    checkOutput("raw_no_dev_re", 64'(re_cycles), 64'(re0));
`else
    checkOutput("raw_rd_after_writes", 64'(rd_at_wr), 64'(wd0 + 2));
    checkOutput("raw_dev_re_seen", 64'(re_cycles > re0), 64'd1);
`endif

    $display("[TB] push and pop together");
    dev_hold = 1'b1;
    applyStimulus(64'h40, 64'h140, 1'b1);
    applyStimulus(64'h41, 64'h141, 1'b1);
    applyStimulus(64'h42, 64'h142, 1'b1);
    applyStimulus(64'h43, 64'h143, 1'b1);
    checkOutput("pp_count_before", 64'(dut.fifo_count), 64'd4);
    dev_hold = 1'b0;
    applyStimulus(64'h44, 64'h144, 1'b1);
    dev_hold = 1'b1;
    checkOutput("pp_count_after", 64'(dut.fifo_count), 64'd4);
    checkOutput("pp_next_head", dev_adderss, 64'h41);
    checkOutput("pp_next_we", 64'(dev_we), 64'd1);
    dev_hold = 1'b0;
    waitDrain("pp");
    checkOutput("pp_count_end", 64'(dut.fifo_count), 64'd0);

    $display("[TB] fill and overflow");
    dev_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(64'h800 + 64'(i * 8), 64'h9000 + 64'(i), 1'b1);
    end
    applyStimulus(64'h830, 64'h9006, 1'b1);
    checkOutput("fill_stop_after7", 64'(read_stop_en), 64'd0);
    applyStimulus(64'h838, 64'h9007, 1'b1);
    checkOutput("fill_stop_after8", 64'(read_stop_en), 64'd1);
    checkOutput("fill_count8", 64'(dut.fifo_count), 64'd8);
    checkOutput("fill_no_ovf", 64'(overflow_err), 64'd0);
    applyStimulus(64'h840, 64'h9008, 1'b0);
    checkOutput("fill_ovf", 64'(overflow_err), 64'd1);
    checkOutput("fill_count_still8", 64'(dut.fifo_count), 64'd8);
    dev_hold = 1'b0;
    waitDrain("fill");
    checkOutput("fill_ovf_sticky", 64'(overflow_err), 64'd1);

    $display("[TB] reset during device read");
    dev_hold   = 1'b1;
    rd_adderss = 64'h500;
    rd_req     = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dev_re && n < 10);
    checkOutput("rstrd_dev_re_seen", 64'(dev_re), 64'd1);
    rv0   = rv_cnt;
    reset = 1'b0;
    #1;
    checkOutput("rstrd_dev_re", 64'(dev_re), 64'd0);
    checkOutput("rstrd_count", 64'(dut.fifo_count), 64'd0);
    checkOutput("rstrd_ovf", 64'(overflow_err), 64'd0);
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    dev_hold = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstrd_no_rd_valid", 64'(rv_cnt), 64'(rv0));
    checkOutput("rstrd_dev_re_idle", 64'(dev_re), 64'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      dev_lat = vecs[i].lat;
      if (vecs[i].is_rd) begin
        doRead(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      end else begin
        applyStimulus(vecs[i].addr, vecs[i].data, 1'b1);
      end
      waitDrain($sformatf("vec%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
